exibe_sequencia_param: RTL and testbench
========================================

Name: exibe_sequencia_param

Overview:
Parametrised sequence-playback engine for the jogo_mindfocus family. It replaces the fixed 4-LED, fixed-timing display path. It reads a stored sequence from an external synchronous memory and lights one channel per step for a programmable on-time, then holds a blank gap. An optional speed-up mode shortens the on-time as the round length grows. The game FSM drives it with a start/done handshake.

Parameters:
N_CANAIS, 4, number of LED/button channels (width of one sequence entry)
PROF, 16, maximum sequence depth (memory entries)
T_ACESO, 1000, base LED on-time in clock cycles (1 s at 1 kHz)
T_APAGADO, 100, blank gap after each step in cycles
T_PASSO, 50, on-time reduction per extra step when modo_rapido=1
T_MIN, 200, floor for on-time in speed-up mode
ADDR_W, $clog2(PROF), address width (derived)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
iniciar  in  1  start request, sampled only in IDLE
abortar  in  1  synchronous abort, highest priority after reset
modo_rapido  in  1  1 = speed-up on-time by sequence length
tamanho  in  ADDR_W+1  number of steps to play, 0..PROF; latched at start
mem_addr  out  ADDR_W  registered read address to sequence memory
mem_dado  in  N_CANAIS  memory data, valid 1 cycle after mem_addr
leds  out  N_CANAIS  registered LED drive
ocupado  out  1  high from the cycle after accepted start until return to IDLE
fim  out  1  one-cycle pulse on normal completion
erro_dado  out  1  sticky: some fetched entry was not one-hot; cleared on next accepted start
db_indice  out  ADDR_W  current step index
db_estado  out  4  state code

Behaviour:
- Reset (reset=0, async): state IDLE. leds=0, mem_addr=0, ocupado=0, fim=0, erro_dado=0, db_indice=0, timer=0.
- States: IDLE, BUSCA, CARREGA, ACESO, APAGADO, FIM. Encodings are 0, 1, 2, 3, 4, 5 on db_estado.
- IDLE: when iniciar=1, latch n=min(tamanho,PROF). Clear erro_dado and set idx=0.
  - If n=0, go to FIM.
  - Otherwise compute t_on and go to BUSCA.
- t_on: equals T_ACESO when modo_rapido=0. When modo_rapido=1, t_on = max(T_MIN, T_ACESO - (n-1)*T_PASSO). Compute in an unsigned width wide enough that the subtraction saturates at T_MIN and never wraps.
- BUSCA (1 cycle): mem_addr<=idx.
- CARREGA (1 cycle): capture mem_dado into leds. Set erro_dado if the value is not one-hot, and display the raw value anyway. Load timer with t_on-1.
- ACESO: hold leds for exactly t_on cycles. At timer=0, clear leds, load T_APAGADO-1 and go to APAGADO.
- APAGADO: leds=0 for exactly T_APAGADO cycles. At timer=0:
  - if idx=n-1, go to FIM;
  - else increment idx and go to BUSCA.
- FIM (1 cycle): fim=1, ocupado=0, then IDLE.
- Per-step cost is t_on+T_APAGADO+2 cycles.
- Latency: the accepting edge is cycle 0. FIM is cycle 1+n*(t_on+T_APAGADO+2). For n=0, FIM is cycle 1.
- iniciar while not IDLE: ignored. tamanho changes after start: ignored.
- abortar=1 in any non-IDLE state: next edge forces IDLE with leds=0, ocupado=0 and no fim pulse. erro_dado is kept. In IDLE, abortar has priority over iniciar.
- Reset mid-playback: immediate async return to reset values.
- Wrap-around: idx never exceeds PROF-1. tamanho>PROF is clamped.

Decomposition:
- Shared package mindfocus_pkg holds:
  - state encodings (common db_estado coding with the game FSM);
  - a function for the one-hot check;
  - a clog2-based width constant helper.
- Sub-module temporizador_param: loadable down-counter with load and zero-flag outputs, width parameter.

Test Plan:
Bench parameters are T_ACESO=4, T_APAGADO=2, T_PASSO=1, T_MIN=2, PROF=16. The memory model is one-cycle sync ROM = {0001,0010,0100,1000,...}.

1. reset=0 then 1; tamanho=2, iniciar pulse -> leds=0001 for 4 cycles, 0 for 2, 0010 for 4, 0 for 2. fim high exactly at cycle 17. ocupado high over cycles 1..16.
2. tamanho=0, iniciar -> fim at cycle 1. leds stays 0 and mem_addr is unchanged.
3. modo_rapido=1, tamanho=3 -> t_on=max(2,4-2)=2 for every step. fim at cycle 1+3*6=19. With tamanho=16, t_on saturates at 2 with no wrap.
4. abortar asserted in step 2 ACESO -> next cycle leds=0, ocupado=0, state IDLE, no fim. A new iniciar then replays from index 0.
5. ROM entry 1 = 0110, tamanho=2 -> leds=0110 shown and erro_dado=1 stays set after fim. The next iniciar clears it.
6. reset=0 asserted mid-APAGADO (asynchronously, off-edge) -> all outputs are reset immediately. iniciar during playback is ignored (no restart, same fim cycle). tamanho=20 is clamped to 16 steps.

Source files
------------

// File: rtl/mindfocus_pkg.sv
// Shared definitions for the jogo_mindfocus family.
//   estado_t   : state coding reported on db_estado, common to the game FSM
//   bits_para  : number of bits needed to hold a given non-negative value
//   eh_one_hot : true when exactly one bit of the (zero-extended) value is set
package mindfocus_pkg;

  typedef enum logic [3:0] {
    EST_IDLE    = 4'd0,
    EST_BUSCA   = 4'd1,
    EST_CARREGA = 4'd2,
    EST_ACESO   = 4'd3,
    EST_APAGADO = 4'd4,
    EST_FIM     = 4'd5
  } estado_t;

  function automatic int bits_para(input int valor);
    return (valor < 2) ? 1 : $clog2(valor + 1);
  endfunction

  // Zero-extension does not change one-hotness, so one 32-bit check serves
  // every channel count up to 32.
  function automatic logic eh_one_hot(input logic [31:0] valor);
    return (valor != 32'd0) && ((valor & (valor - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/exibe_sequencia_param_if.sv
// Handshake and memory bus between the game FSM / sequence memory (master)
// and the playback engine (slave).
//   iniciar, abortar, modo_rapido, tamanho : control from the game FSM
//   mem_addr / mem_dado                    : synchronous sequence memory port
//   leds, ocupado, fim, erro_dado          : playback status and LED drive
//   db_indice, db_estado                   : debug taps
interface exibe_sequencia_param_if #(
  parameter int N_CANAIS = 4,
  parameter int ADDR_W   = 4
);
  logic                iniciar;
  logic                abortar;
  logic                modo_rapido;
  logic [ADDR_W:0]     tamanho;
  logic [ADDR_W-1:0]   mem_addr;
  logic [N_CANAIS-1:0] mem_dado;
  logic [N_CANAIS-1:0] leds;
  logic                ocupado;
  logic                fim;
  logic                erro_dado;
  logic [ADDR_W-1:0]   db_indice;
  logic [3:0]          db_estado;

  modport master (
    output iniciar, abortar, modo_rapido, tamanho, mem_dado,
    input  mem_addr, leds, ocupado, fim, erro_dado, db_indice, db_estado
  );

  modport slave (
    input  iniciar, abortar, modo_rapido, tamanho, mem_dado,
    output mem_addr, leds, ocupado, fim, erro_dado, db_indice, db_estado
  );
endinterface

// File: rtl/temporizador_param.sv
// Loadable down-counter. A load takes priority; otherwise the count decrements
// once per cycle and rests at zero.
//   clock, reset : clock and asynchronous active-low reset
//   carregar_i   : load valor_i on the next edge
//   valor_i      : load value
//   zero_o       : count is zero
module temporizador_param #(
  parameter int LARGURA = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               carregar_i,
  input  logic [LARGURA-1:0] valor_i,
  output logic               zero_o
);
  logic [LARGURA-1:0] contagem_q, contagem_d;

  always_comb begin
    contagem_d = contagem_q;
    if (carregar_i)
      contagem_d = valor_i;
    else if (contagem_q != '0)
      contagem_d = contagem_q - LARGURA'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) contagem_q <= '0;
    else        contagem_q <= contagem_d;
  end

  assign zero_o = (contagem_q == '0);
endmodule

// File: rtl/exibe_sequencia_param.sv
// Sequence playback engine: fetches each stored entry, lights it for t_on
// cycles, blanks for T_APAGADO cycles, and reports completion with fim.
//   clock, reset : clock and asynchronous active-low reset
//   bus          : control, memory and status signals (slave side)
module exibe_sequencia_param
  import mindfocus_pkg::*;
#(
  parameter int N_CANAIS  = 4,
  parameter int PROF      = 16,
  parameter int T_ACESO   = 1000,
  parameter int T_APAGADO = 100,
  parameter int T_PASSO   = 50,
  parameter int T_MIN     = 200,
  parameter int ADDR_W    = (PROF > 1) ? $clog2(PROF) : 1
) (
  input  logic              clock,
  input  logic              reset,
  exibe_sequencia_param_if.slave bus
);
  localparam int T_MAIOR = (T_ACESO > T_APAGADO)
                         ? ((T_ACESO > T_MIN) ? T_ACESO : T_MIN)
                         : ((T_APAGADO > T_MIN) ? T_APAGADO : T_MIN);
  localparam int TW = bits_para(T_MAIOR);
  localparam logic [ADDR_W:0] PROF_V  = (ADDR_W+1)'(PROF);
  localparam logic [31:0]     ACESO_U = 32'(T_ACESO);
  localparam logic [31:0]     MIN_U   = 32'(T_MIN);

  estado_t             estado_q, estado_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic [TW-1:0]       t_on_q, t_on_d;
  logic [N_CANAIS-1:0] leds_q, leds_d;
  logic                erro_q, erro_d;

  logic                carregar;
  logic [TW-1:0]       valor_carga;
  logic                timer_zero;
  logic [ADDR_W:0]     n_entrada;
  logic [31:0]         reducao;
  logic [TW-1:0]       t_on_calc;

  // Step length after clamping, and the speed-up on-time. The reduction is
  // compared before subtracting so the result saturates at T_MIN instead of
  // wrapping for long rounds.
  always_comb begin
    n_entrada = (bus.tamanho > PROF_V) ? PROF_V : bus.tamanho;
    reducao   = (32'(n_entrada) - 32'd1) * 32'(T_PASSO);
    if (!bus.modo_rapido)
      t_on_calc = TW'(T_ACESO);
    else if ((reducao >= ACESO_U) || ((ACESO_U - reducao) < MIN_U))
      t_on_calc = TW'(T_MIN);
    else
      t_on_calc = TW'(ACESO_U - reducao);
  end

  always_comb begin
    estado_d    = estado_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    n_d         = n_q;
    t_on_d      = t_on_q;
    leds_d      = leds_q;
    erro_d      = erro_q;
    carregar    = 1'b0;
    valor_carga = '0;

    if (bus.abortar && (estado_q != EST_IDLE)) begin
      estado_d = EST_IDLE;
      leds_d   = '0;
    end else begin
      case (estado_q)
        EST_IDLE: begin
          if (bus.iniciar && !bus.abortar) begin
            n_d    = n_entrada;
            idx_d  = '0;
            erro_d = 1'b0;
            if (n_entrada == '0) begin
              estado_d = EST_FIM;
            end else begin
              t_on_d   = t_on_calc;
              // The address is presented while in BUSCA so a memory with a
              // registered read has its data ready throughout CARREGA.
              addr_d   = '0;
              estado_d = EST_BUSCA;
            end
          end
        end
        EST_BUSCA: estado_d = EST_CARREGA;
        EST_CARREGA: begin
          leds_d = bus.mem_dado;
          if (!eh_one_hot(32'(bus.mem_dado)))
            erro_d = 1'b1;
          carregar    = 1'b1;
          valor_carga = t_on_q - TW'(1);
          estado_d    = EST_ACESO;
        end
        EST_ACESO: begin
          if (timer_zero) begin
            leds_d      = '0;
            carregar    = 1'b1;
            valor_carga = TW'(T_APAGADO - 1);
            estado_d    = EST_APAGADO;
          end
        end
        EST_APAGADO: begin
          if (timer_zero) begin
            if ({1'b0, idx_q} == (n_q - (ADDR_W+1)'(1))) begin
              estado_d = EST_FIM;
            end else begin
              idx_d    = idx_q + ADDR_W'(1);
              addr_d   = idx_q + ADDR_W'(1);
              estado_d = EST_BUSCA;
            end
          end
        end
        EST_FIM: estado_d = EST_IDLE;
        default: estado_d = EST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= EST_IDLE;
      idx_q    <= '0;
      addr_q   <= '0;
      n_q      <= '0;
      t_on_q   <= '0;
      leds_q   <= '0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      n_q      <= n_d;
      t_on_q   <= t_on_d;
      leds_q   <= leds_d;
      erro_q   <= erro_d;
    end
  end

  temporizador_param #(.LARGURA(TW)) u_temporizador (
    .clock      (clock),
    .reset      (reset),
    .carregar_i (carregar),
    .valor_i    (valor_carga),
    .zero_o     (timer_zero)
  );

  assign bus.leds      = leds_q;
  assign bus.mem_addr  = addr_q;
  assign bus.erro_dado = erro_q;
  assign bus.db_indice = idx_q;
  assign bus.db_estado = estado_q;
  assign bus.fim       = (estado_q == EST_FIM);
  assign bus.ocupado   = (estado_q != EST_IDLE) && (estado_q != EST_FIM);
endmodule

// File: tb/tb_exibe_sequencia_param.sv
// Directed bench for exibe_sequencia_param with short timings
// (T_ACESO=4, T_APAGADO=2, T_PASSO=1, T_MIN=2, PROF=16) and a one-cycle
// synchronous ROM holding {0001,0010,0100,1000,...}.
module tb_exibe_sequencia_param;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  exibe_sequencia_param_if #(.N_CANAIS(4), .ADDR_W(4)) bus ();

  exibe_sequencia_param #(
    .N_CANAIS(4), .PROF(16), .T_ACESO(4), .T_APAGADO(2), .T_PASSO(1), .T_MIN(2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [3:0] rom [16];
  always @(posedge clock) bus.mem_dado <= rom[bus.mem_addr];

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  int cap_leds [200];
  int cap_fim  [200];
  int cap_ocup [200];
  int cap_est  [200];
  int cap_erro [200];
  int cap_idx  [200];

  int exp1_leds [18] = '{0,0,1,1,1,1,0,0,0,0,2,2,2,2,0,0,0,0};
  int exp1_ocup [18] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0,0};
  int exp1_fim  [18] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0};
  int exp1_est  [18] = '{1,2,3,3,3,3,4,4,1,2,3,3,3,3,4,4,5,0};

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 (accepting edge = cycle 0).
  task automatic inicia(input logic [4:0] tam, input logic rapido);
    bus.tamanho     = tam;
    bus.modo_rapido = rapido;
    bus.iniciar     = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.iniciar = 1'b0;
  endtask

  // Samples cycles 1..ncic; optionally pulses iniciar (with a new tamanho)
  // at cycle ciclo_pulso to show it is ignored mid-playback.
  task automatic captura(input int ncic, input int ciclo_pulso);
    for (int c = 1; c <= ncic; c++) begin
      cap_leds[c] = int'(bus.leds);
      cap_fim[c]  = int'(bus.fim);
      cap_ocup[c] = int'(bus.ocupado);
      cap_est[c]  = int'(bus.db_estado);
      cap_erro[c] = int'(bus.erro_dado);
      cap_idx[c]  = int'(bus.db_indice);
      if (c == ciclo_pulso) begin
        bus.iniciar = 1'b1;
        bus.tamanho = 5'd5;
      end else begin
        bus.iniciar = 1'b0;
      end
      @(negedge clock);
    end
    bus.iniciar = 1'b0;
  endtask

  function automatic int primeiro_fim(input int ncic);
    for (int c = 1; c <= ncic; c++)
      if (cap_fim[c] == 1) return c;
    return -1;
  endfunction

  function automatic int conta_fim(input int ncic);
    int total = 0;
    for (int c = 1; c <= ncic; c++) total += cap_fim[c];
    return total;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'b0001 << (i % 4);
    bus.iniciar     = 1'b0;
    bus.abortar     = 1'b0;
    bus.modo_rapido = 1'b0;
    bus.tamanho     = '0;

    // Reset values
    #12;
    chk("rst_leds",    int'(bus.leds), 0);
    chk("rst_addr",    int'(bus.mem_addr), 0);
    chk("rst_ocupado", int'(bus.ocupado), 0);
    chk("rst_fim",     int'(bus.fim), 0);
    chk("rst_erro",    int'(bus.erro_dado), 0);
    chk("rst_indice",  int'(bus.db_indice), 0);
    chk("rst_estado",  int'(bus.db_estado), 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // 1: two steps, normal timing, cycle-accurate trace
    inicia(5'd2, 1'b0);
    captura(18, 0);
    for (int c = 1; c <= 18; c++) begin
      chk($sformatf("t1_leds_c%0d", c), cap_leds[c], exp1_leds[c-1]);
      chk($sformatf("t1_ocup_c%0d", c), cap_ocup[c], exp1_ocup[c-1]);
      chk($sformatf("t1_fim_c%0d",  c), cap_fim[c],  exp1_fim[c-1]);
      chk($sformatf("t1_est_c%0d",  c), cap_est[c],  exp1_est[c-1]);
    end
    $display("t1 two-step playback done, fim at cycle %0d", primeiro_fim(18));

    // 2: empty round finishes at cycle 1 without touching mem_addr (left at 1)
    inicia(5'd0, 1'b0);
    chk("t2_fim_c1",    int'(bus.fim), 1);
    chk("t2_ocup_c1",   int'(bus.ocupado), 0);
    chk("t2_leds_c1",   int'(bus.leds), 0);
    chk("t2_addr_c1",   int'(bus.mem_addr), 1);
    chk("t2_estado_c1", int'(bus.db_estado), 5);
    @(negedge clock);
    chk("t2_fim_c2",    int'(bus.fim), 0);
    chk("t2_estado_c2", int'(bus.db_estado), 0);
    $display("t2 empty round done");

    // 3: speed-up, three steps: t_on = 2, step cost 6, fim at 19
    inicia(5'd3, 1'b1);
    captura(25, 0);
    chk("t3_fim_cycle", primeiro_fim(25), 19);
    chk("t3_fim_count", conta_fim(25), 1);
    chk("t3_leds_c3",  cap_leds[3], 1);
    chk("t3_leds_c4",  cap_leds[4], 1);
    chk("t3_leds_c5",  cap_leds[5], 0);
    chk("t3_leds_c9",  cap_leds[9], 2);
    chk("t3_leds_c11", cap_leds[11], 0);
    chk("t3_leds_c15", cap_leds[15], 4);
    chk("t3_leds_c17", cap_leds[17], 0);
    $display("t3 speed-up n=3 done, fim at cycle %0d", primeiro_fim(25));

    // 3b: speed-up, one step keeps the full on-time: fim at 1+8
    inicia(5'd1, 1'b1);
    captura(12, 0);
    chk("t3b_fim_cycle", primeiro_fim(12), 9);
    chk("t3b_leds_c6",   cap_leds[6], 1);
    $display("t3b speed-up n=1 done, fim at cycle %0d", primeiro_fim(12));

    // 3c: speed-up, sixteen steps saturates at T_MIN: fim at 1+16*6
    inicia(5'd16, 1'b1);
    captura(110, 0);
    chk("t3c_fim_cycle", primeiro_fim(110), 97);
    chk("t3c_leds_c93",  cap_leds[93], 8);
    chk("t3c_leds_c95",  cap_leds[95], 0);
    chk("t3c_idx_c93",   cap_idx[93], 15);
    $display("t3c speed-up n=16 done, fim at cycle %0d", primeiro_fim(110));

    // 4: abort during step 2 on-time, then replay from index 0
    inicia(5'd3, 1'b0);
    repeat (11) @(negedge clock);
    chk("t4_leds_c12", int'(bus.leds), 2);
    bus.abortar = 1'b1;
    @(negedge clock);
    bus.abortar = 1'b0;
    chk("t4_leds_abort",   int'(bus.leds), 0);
    chk("t4_ocup_abort",   int'(bus.ocupado), 0);
    chk("t4_estado_abort", int'(bus.db_estado), 0);
    chk("t4_fim_abort",    int'(bus.fim), 0);
    captura(6, 0);
    chk("t4_no_fim_after", conta_fim(6), 0);
    inicia(5'd1, 1'b0);
    captura(12, 0);
    chk("t4_replay_leds_c3", cap_leds[3], 1);
    chk("t4_replay_idx_c3",  cap_idx[3], 0);
    chk("t4_replay_fim",     primeiro_fim(12), 9);
    $display("t4 abort and replay done");

    // 5: non-one-hot entry is shown and flags erro_dado until the next start
    rom[1] = 4'b0110;
    inicia(5'd2, 1'b0);
    captura(20, 0);
    chk("t5_erro_c3",   cap_erro[3], 0);
    chk("t5_leds_c11",  cap_leds[11], 6);
    chk("t5_erro_c11",  cap_erro[11], 1);
    chk("t5_fim_cycle", primeiro_fim(20), 17);
    chk("t5_erro_c19",  cap_erro[19], 1);
    rom[1] = 4'b0010;
    inicia(5'd1, 1'b0);
    chk("t5_erro_cleared", int'(bus.erro_dado), 0);
    captura(10, 0);
    chk("t5_erro_stays_clear", cap_erro[10], 0);
    $display("t5 data error flag done");

    // 6a: iniciar and tamanho changes during playback are ignored
    inicia(5'd2, 1'b0);
    captura(20, 5);
    chk("t6a_fim_cycle", primeiro_fim(20), 17);
    chk("t6a_fim_count", conta_fim(20), 1);
    chk("t6a_est_c19",   cap_est[19], 0);
    $display("t6a mid-playback iniciar ignored");

    // 6b: tamanho=20 clamps to 16 steps: fim at 1+16*8
    inicia(5'd20, 1'b0);
    captura(140, 0);
    chk("t6b_fim_cycle", primeiro_fim(140), 129);
    chk("t6b_leds_c123", cap_leds[123], 8);
    chk("t6b_idx_c123",  cap_idx[123], 15);
    $display("t6b clamp done, fim at cycle %0d", primeiro_fim(140));

    // 6c: asynchronous reset in step 2 blank gap
    inicia(5'd2, 1'b0);
    repeat (14) @(negedge clock);
    chk("t6c_estado_pre", int'(bus.db_estado), 4);
    chk("t6c_idx_pre",    int'(bus.db_indice), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6c_estado_rst", int'(bus.db_estado), 0);
    chk("t6c_idx_rst",    int'(bus.db_indice), 0);
    chk("t6c_addr_rst",   int'(bus.mem_addr), 0);
    chk("t6c_ocup_rst",   int'(bus.ocupado), 0);
    chk("t6c_leds_rst",   int'(bus.leds), 0);
    @(negedge clock);
    reset = 1'b1;
    $display("t6c async reset done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
